// File: rtl/la_dpram_reader.sv
// -----------------------------------------------------------------------------
// la_dpram_reader
//
// Streaming read engine for the read port of la_dpram. A start command latches
// a start address and a word count. The engine then reads that many
// consecutive words from the RAM and presents them, in address order, on a
// valid/ready stream. A 2-entry output buffer absorbs the RAM's 1-cycle read
// latency and any consumer backpressure, so one word per cycle is sustained
// while out_ready stays high.
//
// Parameters
//   DW    data width (must match the RAM)
//   AW    address width (must match the RAM)
//   LENW  width of the transfer-length field
//
// Ports
//   clk         in   single clock, shared with the RAM read port
//   rst         in   asynchronous reset, active-high
//   start       in   one-cycle command strobe, honoured only while idle
//   start_addr  in   first word address
//   len         in   number of words to read (0 is legal)
//   busy        out  transfer in progress (RUN, DRAIN, DONE)
//   done        out  one-cycle completion pulse
//   rd_ce       out  RAM read enable
//   rd_addr     out  RAM read address
//   rd_dout     in   RAM read data, valid one clock after rd_ce
//   out_valid   out  stream data valid
//   out_data    out  stream data (buffer head)
//   out_ready   in   consumer accept
// -----------------------------------------------------------------------------
module la_dpram_reader #(
    parameter int DW   = 32,
    parameter int AW   = 10,
    parameter int LENW = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   start_addr,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    output logic            rd_ce,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_dout,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LENW-1:0] LEN_ZERO = '0;
    localparam logic [LENW-1:0] LEN_ONE  = {{(LENW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    // Control state
    state_t          state_q,    state_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic [AW-1:0]   addr_q,     addr_d;
    logic [LENW-1:0] len_q,      len_d;
    logic [LENW-1:0] issued_q,   issued_d;
    logic [LENW-1:0] accepted_q, accepted_d;
    logic            inflight_q, inflight_d;

    // Output buffer: buf0 is always the head, buf1 the second entry
    logic [1:0]      occ_q,      occ_d;
    logic [DW-1:0]   buf0_q,     buf0_d;
    logic [DW-1:0]   buf1_q,     buf1_d;

    logic            pop;
    logic            issue;
    logic [2:0]      level;
    logic            last_issue;
    logic            last_accept;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf0_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_addr   = addr_q;

    assign pop = out_valid & out_ready;

    // Entries the buffer will hold once the read in flight lands and this
    // cycle's pop leaves. A pop implies occ >= 1, so this never underflows.
    // Issuing only while this is below 2 guarantees the word returned next
    // cycle always has a free slot.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign issue = (state_q == S_RUN) && (issued_q != len_q) && (level < 3'd2);
    assign rd_ce = issue;

    assign last_issue  = issue && ((issued_q + LEN_ONE) == len_q);
    assign last_accept = pop && ((accepted_q + LEN_ONE) == len_q);

    // Buffer next-state: the RAM word arrives exactly one cycle after rd_ce
    // and is written unconditionally; a pop shifts buf1 into the head.
    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        unique case ({inflight_q, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    buf0_d = rd_dout;
                end else begin
                    buf1_d = rd_dout;
                end
            end
            2'b01: begin
                occ_d  = occ_q - 2'd1;
                buf0_d = buf1_q;
            end
            2'b11: begin
                // Capture and pop together: occupancy unchanged.
                if (occ_q == 2'd1) begin
                    buf0_d = rd_dout;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = rd_dout;
                end
            end
            default: begin
            end
        endcase
    end

    // Transfer control next-state
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        accepted_d = accepted_q + {{(LENW-1){1'b0}}, pop};
        inflight_d = issue;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = start_addr;
                    len_d      = len;
                    issued_d   = LEN_ZERO;
                    accepted_d = LEN_ZERO;
                    busy_d     = 1'b1;
                    if (len == LEN_ZERO) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_ONE;
                    issued_d = issued_q + LEN_ONE;
                end
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_accept) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_la_dpram_reader.sv
module tb_la_dpram_reader;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int LENW = 11;
    localparam int MEMN = 1 << AW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   start_addr = '0;
    logic [LENW-1:0] len = '0;
    logic            busy;
    logic            done;
    logic            rd_ce;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_dout = '0;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready = 1'b0;

    logic [DW-1:0]   mem [0:MEMN-1];

    int n_cmp = 0;
    int n_err = 0;

    la_dpram_reader #(.DW(DW), .AW(AW), .LENW(LENW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rd_ce      (rd_ce),
        .rd_addr    (rd_addr),
        .rd_dout    (rd_dout),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // RAM read port stand-in: one-cycle registered read.
    always @(posedge clk) begin
        if (rd_ce) rd_dout <= mem[rd_addr];
    end

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       return $urandom_range(0, 3) != 0;
            default: return $urandom_range(0, 1) == 1;
        endcase
    endfunction

    // Drives one transfer and checks it against the specification's rules.
    // mode: 0 ready always high (exact cycle timing checked), 1 pattern
    // 1,0,0,1, 2/3 random ready. restart_cyc: cycle in which a stray start
    // is pulsed (-1 none). rst_cyc: cycle in which reset aborts (-1 none).
    task automatic run_xfer(input string tag, input logic [AW-1:0] a, input int n,
                            input int mode, input int restart_cyc, input int rst_cyc);
        logic [DW-1:0] exp_q[$];
        logic [AW-1:0] ad;
        logic [DW-1:0] hold_d;
        logic          hold_v;
        logic [3:0]    exp_vec;
        int issued, acc, done_seen, done_cyc, last_acc_cyc, exp_done_cyc, limit, cyc;
        bit fin;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            ad = a + AW'(k);
            exp_q.push_back(mem[ad]);
        end
        issued = 0; acc = 0; done_seen = 0; done_cyc = -1; last_acc_cyc = -1;
        hold_v = 1'b0; hold_d = '0; fin = 1'b0;
        limit = 8 * n + 30;
        exp_done_cyc = (n == 0) ? 1 : n + 3;

        // Cycle 0: command
        @(negedge clk);
        start = 1'b1; start_addr = a; len = LENW'(n);
        out_ready = ready_for(mode, 0);
        cyc = 1;
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == restart_cyc) begin
                start      = 1'b1;
                start_addr = AW'($urandom);
                len        = LENW'($urandom_range(1, 9));
            end
            out_ready = ready_for(mode, cyc);
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                #1;
                n_cmp++;
                if ({busy, done, rd_ce, out_valid} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL %s rst_ctrl: got busy/done/rd_ce/valid=%b want 0000", tag,
                             {busy, done, rd_ce, out_valid});
                end
                n_cmp++;
                if (rd_addr !== '0 || out_data !== '0) begin
                    n_err++;
                    $display("FAIL %s rst_data: got addr=%h data=%h want 0/0", tag, rd_addr, out_data);
                end
                @(negedge clk);
                rst = 1'b0; start = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    #1;
                    n_cmp++;
                    if ({busy, done, rd_ce, out_valid} !== 4'b0000) begin
                        n_err++;
                        $display("FAIL %s post_rst_idle: got busy/done/rd_ce/valid=%b want 0000", tag,
                                 {busy, done, rd_ce, out_valid});
                    end
                end
                return;
            end
            #1;
            // Entries held or in flight: never more than the 2-entry buffer.
            n_cmp++;
            if (issued - acc > 2) begin
                n_err++;
                $display("FAIL %s occupancy: got %0d outstanding want <=2", tag, issued - acc);
            end
            if (rd_ce) begin
                n_cmp++;
                if (issued >= n) begin
                    n_err++;
                    $display("FAIL %s extra_read: got read #%0d want only %0d", tag, issued + 1, n);
                end else begin
                    ad = a + AW'(issued);
                    if (rd_addr !== ad) begin
                        n_err++;
                        $display("FAIL %s rd_addr: got %h want %h", tag, rd_addr, ad);
                    end
                end
                issued++;
            end
            if (hold_v) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== hold_d) begin
                    n_err++;
                    $display("FAIL %s hold: got valid=%b data=%h want 1/%h", tag, out_valid, out_data, hold_d);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (acc >= n) begin
                    n_err++;
                    $display("FAIL %s extra_beat: got beat #%0d want only %0d", tag, acc + 1, n);
                end else if (out_data !== exp_q[acc]) begin
                    n_err++;
                    $display("FAIL %s out_data[%0d]: got %h want %h", tag, acc, out_data, exp_q[acc]);
                end
                acc++;
                last_acc_cyc = cyc;
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (mode == 0) begin
                exp_vec = {(cyc <= exp_done_cyc),
                           (cyc >= 1 && cyc <= n),
                           (cyc >= 3 && cyc <= n + 2),
                           (cyc == exp_done_cyc)};
                n_cmp++;
                if ({busy, rd_ce, out_valid, done} !== exp_vec) begin
                    n_err++;
                    $display("FAIL %s timing c%0d: got busy/rd_ce/valid/done=%b want %b", tag, cyc,
                             {busy, rd_ce, out_valid, done}, exp_vec);
                end
            end
            if (done) begin
                done_seen++;
                if (done_seen == 1) done_cyc = cyc;
                n_cmp++;
                if (acc != n || (n > 0 && cyc != last_acc_cyc + 1)) begin
                    n_err++;
                    $display("FAIL %s done_when: got c%0d beats=%0d want c%0d beats=%0d", tag, cyc, acc,
                             last_acc_cyc + 1, n);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s after_done: got busy=%b done=%b want 0/0", tag, busy, done);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1'b1;
            if (cyc >= limit) begin
                n_cmp++; n_err++;
                $display("FAIL %s timeout: got no done after %0d cycles want done", tag, cyc);
                fin = 1'b1;
            end
            cyc++;
        end
        n_cmp++;
        if (issued != n || acc != n || done_seen != 1) begin
            n_err++;
            $display("FAIL %s totals: got reads=%0d beats=%0d dones=%0d want %0d/%0d/1", tag,
                     issued, acc, done_seen, n, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, done, rd_ce, out_valid} !== 4'b0000 || rd_addr !== '0 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset: got ctrl=%b addr=%h data=%h want 0000/0/0",
                     {busy, done, rd_ce, out_valid}, rd_addr, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < MEMN; i++) mem[i] = DW'(i);
        run_xfer("basic", AW'('h010), 4, 0, -1, -1);
    endtask

    task automatic test_len0();
        run_xfer("len0", AW'('h123), 0, 0, -1, -1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < MEMN; i++) mem[i] = $urandom;
        run_xfer("wrap", AW'('h3FE), 4, 0, -1, -1);
    endtask

    task automatic test_backpressure();
        run_xfer("bp", AW'($urandom), 8, 1, -1, -1);
    endtask

    task automatic test_restart_ignored();
        run_xfer("restart", AW'($urandom), 6, 0, 2, -1);
    endtask

    task automatic test_abort();
        run_xfer("abort", AW'('h040), 16, 0, -1, 3);
        run_xfer("after_abort", AW'('h200), 2, 0, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < MEMN; i++) mem[i] = $urandom;
            run_xfer("random", AW'($urandom), $urandom_range(0, 24), 2 + (t % 2), -1, -1);
        end
    endtask

    initial begin
        for (int i = 0; i < MEMN; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_backpressure();
        test_restart_ignored();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
